spike_readout: RTL and testbench

Windowed readout stage that sits directly downstream of the hidden LIF layer. It counts the spikes each class neuron fires over a fixed window of cycles, then runs a sequential arg-max scan over the counts. It reports the winning class, its count and a tie flag with a one-cycle valid pulse. It replaces the free-running 8-bit accumulator plus per-cycle combinational max, which wraps at 256 and never clears.

---
 rtl/snn_pkg.sv | 16 +
 rtl/sat_counter.sv | 34 +++
 rtl/spike_readout.sv | 137 +++++++++++++
 tb/tb_spike_readout.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and defaults for the SNN readout path.
package snn_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StScan,
    StDone
  } readout_state_t;

  localparam logic [7:0] CLASS_NONE = 8'hFF;

  localparam int unsigned COUNT_W_DEF    = 8;
  localparam int unsigned WINDOW_LEN_DEF = 64;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  // Clear wins over enable; the counter holds once it reaches all-ones.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/spike_readout.sv
// Windowed spike counting per class followed by a sequential arg-max scan.
module spike_readout
  import snn_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned COUNT_W     = COUNT_W_DEF,
  parameter int unsigned WINDOW_LEN  = WINDOW_LEN_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [NUM_CLASSES-1:0] spikes_i,
  output logic                   busy_o,
  output logic                   valid_o,
  output logic [7:0]             class_o,
  output logic [COUNT_W-1:0]     count_o,
  output logic                   tie_o
);

  localparam int unsigned WinW = $clog2(WINDOW_LEN + 1);
  localparam logic [WinW-1:0] WinLast = WinW'(WINDOW_LEN - 1);
  localparam logic [7:0] IdxLast = 8'(NUM_CLASSES - 1);

  readout_state_t state_q;

  logic [WinW-1:0]    win_q;
  logic [7:0]         idx_q;
  logic [7:0]         best_idx_q;
  logic [COUNT_W-1:0] best_cnt_q;
  logic               best_tie_q;

  logic               busy_q;
  logic               valid_q;
  logic [7:0]         class_q;
  logic [COUNT_W-1:0] count_q;
  logic               tie_q;

  logic               cnt_clr;
  logic [COUNT_W-1:0] cnt [NUM_CLASSES];
  logic [COUNT_W-1:0] sel_cnt;

  assign cnt_clr = (state_q == StIdle) && start_i;

  for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_cnt
    sat_counter #(
      .Width(COUNT_W)
    ) u_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (cnt_clr),
      .en_i   ((state_q == StAccum) && spikes_i[i]),
      .count_o(cnt[i])
    );
  end

  // Scan mux; written as a compare loop so the 8-bit index never truncates.
  always_comb begin
    sel_cnt = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (idx_q == 8'(i)) begin
        sel_cnt = cnt[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      win_q      <= '0;
      idx_q      <= '0;
      best_idx_q <= CLASS_NONE;
      best_cnt_q <= '0;
      best_tie_q <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      class_q    <= CLASS_NONE;
      count_q    <= '0;
      tie_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q    <= StAccum;
            busy_q     <= 1'b1;
            win_q      <= '0;
            idx_q      <= '0;
            best_idx_q <= CLASS_NONE;
            best_cnt_q <= '0;
            best_tie_q <= 1'b0;
          end
        end
        StAccum: begin
          if (win_q == WinLast) begin
            state_q <= StScan;
          end else begin
            win_q <= win_q + WinW'(1);
          end
        end
        StScan: begin
          // Strict compare keeps the lowest index on ties.
          if (sel_cnt > best_cnt_q) begin
            best_idx_q <= idx_q;
            best_cnt_q <= sel_cnt;
            best_tie_q <= 1'b0;
          end else if ((sel_cnt == best_cnt_q) && (best_cnt_q != '0)) begin
            best_tie_q <= 1'b1;
          end
          if (idx_q == IdxLast) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
          end else begin
            idx_q <= idx_q + 8'd1;
          end
        end
        StDone: begin
          class_q <= best_idx_q;
          count_q <= best_cnt_q;
          tie_q   <= best_tie_q;
          valid_q <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign class_o = class_q;
  assign count_o = count_q;
  assign tie_o   = tie_q;

endmodule

// File: tb/tb_spike_readout.sv
// Directed bench for spike_readout: default instance plus a 4-bit-count instance.
module tb_spike_readout;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [9:0] spikes_a = '0, spikes_b = '0;

  logic       busy_a, valid_a, tie_a;
  logic [7:0] class_a, count_a;
  logic       busy_b, valid_b, tie_b;
  logic [7:0] class_b;
  logic [3:0] count_b;

  int n_tests = 0;
  int n_fail  = 0;

  int   lat, pulses;
  logic busy1, busy73, busy74, busy_end;

  always #5 clk = ~clk;

  spike_readout #(
    .NUM_CLASSES(10),
    .COUNT_W    (8),
    .WINDOW_LEN (64)
  ) dut_a (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start_a),
    .spikes_i(spikes_a),
    .busy_o  (busy_a),
    .valid_o (valid_a),
    .class_o (class_a),
    .count_o (count_a),
    .tie_o   (tie_a)
  );

  spike_readout #(
    .NUM_CLASSES(10),
    .COUNT_W    (4),
    .WINDOW_LEN (64)
  ) dut_b (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start_b),
    .spikes_i(spikes_b),
    .busy_o  (busy_b),
    .valid_o (valid_b),
    .class_o (class_b),
    .count_o (count_b),
    .tie_o   (tie_b)
  );

  task automatic drive(input bit sel_b, input logic st, input logic [9:0] sp);
    if (sel_b) begin
      start_b  = st;
      spikes_b = sp;
    end else begin
      start_a  = st;
      spikes_a = sp;
    end
  endtask

  // Runs one window; pat_odd/pat_even are applied on odd/even sample edges E+k.
  // With noisy set, start_i is held high through ACCUM, SCAN and DONE.
  task automatic do_window(input bit sel_b, input logic [9:0] pat_odd,
                           input logic [9:0] pat_even, input bit noisy);
    logic v, b;
    logic [9:0] sp;
    lat = -1;
    pulses = 0;
    @(negedge clk);
    drive(sel_b, 1'b1, '0);
    @(posedge clk);
    @(negedge clk);
    for (int k = 1; k <= 100; k++) begin
      if (k <= 64) sp = (k % 2 == 1) ? pat_odd : pat_even;
      else sp = 10'h3FF;
      drive(sel_b, noisy && (k >= 2) && (k <= 75), sp);
      @(posedge clk);
      @(negedge clk);
      v = sel_b ? valid_b : valid_a;
      b = sel_b ? busy_b : busy_a;
      if (v) begin
        pulses++;
        if (lat < 0) lat = k;
      end
      if (k == 1)   busy1 = b;
      if (k == 73)  busy73 = b;
      if (k == 74)  busy74 = b;
      if (k == 100) busy_end = b;
    end
    drive(sel_b, 1'b0, '0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (busy_a !== 1'b0) begin n_fail++;
      $display("FAIL reset_busy: got %b expected 0", busy_a); end
    n_tests++; if (valid_a !== 1'b0) begin n_fail++;
      $display("FAIL reset_valid: got %b expected 0", valid_a); end
    n_tests++; if (class_a !== 8'hFF) begin n_fail++;
      $display("FAIL reset_class: got %h expected ff", class_a); end
    n_tests++; if (count_a !== 8'd0) begin n_fail++;
      $display("FAIL reset_count: got %0d expected 0", count_a); end
    n_tests++; if (tie_a !== 1'b0) begin n_fail++;
      $display("FAIL reset_tie: got %b expected 0", tie_a); end
    n_tests++; if (class_b !== 8'hFF) begin n_fail++;
      $display("FAIL reset_class_b: got %h expected ff", class_b); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_held;
    do_window(1'b0, 10'b0000001000, 10'b0000001000, 1'b0);
    n_tests++; if (lat != 75) begin n_fail++;
      $display("FAIL held_latency: got %0d expected 75", lat); end
    n_tests++; if (pulses != 1) begin n_fail++;
      $display("FAIL held_pulses: got %0d expected 1", pulses); end
    n_tests++; if (class_a !== 8'd3) begin n_fail++;
      $display("FAIL held_class: got %0d expected 3", class_a); end
    n_tests++; if (count_a !== 8'd64) begin n_fail++;
      $display("FAIL held_count: got %0d expected 64", count_a); end
    n_tests++; if (tie_a !== 1'b0) begin n_fail++;
      $display("FAIL held_tie: got %b expected 0", tie_a); end
    n_tests++; if (busy1 !== 1'b1 || busy73 !== 1'b1 || busy74 !== 1'b0) begin n_fail++;
      $display("FAIL held_busy: got %b%b%b expected 110", busy1, busy73, busy74); end
  endtask

  task automatic test_tie;
    do_window(1'b0, 10'b0010000100, 10'b0000000000, 1'b0);
    n_tests++; if (class_a !== 8'd2) begin n_fail++;
      $display("FAIL tie_class: got %0d expected 2", class_a); end
    n_tests++; if (count_a !== 8'd32) begin n_fail++;
      $display("FAIL tie_count: got %0d expected 32", count_a); end
    n_tests++; if (tie_a !== 1'b1) begin n_fail++;
      $display("FAIL tie_flag: got %b expected 1", tie_a); end
    n_tests++; if (pulses != 1) begin n_fail++;
      $display("FAIL tie_pulses: got %0d expected 1", pulses); end
  endtask

  // Class 4 spikes every cycle, class 8 on odd edges, class 1 on even edges.
  task automatic test_mixed;
    do_window(1'b0, 10'b0100010000, 10'b0000010010, 1'b0);
    n_tests++; if (class_a !== 8'd4) begin n_fail++;
      $display("FAIL mixed_class: got %0d expected 4", class_a); end
    n_tests++; if (count_a !== 8'd64) begin n_fail++;
      $display("FAIL mixed_count: got %0d expected 64", count_a); end
    n_tests++; if (tie_a !== 1'b0) begin n_fail++;
      $display("FAIL mixed_tie: got %b expected 0", tie_a); end
  endtask

  task automatic test_reset_mid_window;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a  = 1'b0;
    spikes_a = 10'h3FF;
    repeat (29) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if (busy_a !== 1'b0) begin n_fail++;
      $display("FAIL midrst_busy: got %b expected 0", busy_a); end
    n_tests++; if (class_a !== 8'hFF) begin n_fail++;
      $display("FAIL midrst_class: got %h expected ff", class_a); end
    n_tests++; if (count_a !== 8'd0) begin n_fail++;
      $display("FAIL midrst_count: got %0d expected 0", count_a); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    spikes_a = '0;
    pulses = 0;
    repeat (80) begin
      @(negedge clk);
      if (valid_a) pulses++;
    end
    n_tests++; if (pulses != 0 || busy_a !== 1'b0) begin n_fail++;
      $display("FAIL midrst_quiet: got pulses=%0d busy=%b expected 0 0", pulses, busy_a); end
    do_window(1'b0, 10'b0001000000, 10'b0001000000, 1'b0);
    n_tests++; if (lat != 75) begin n_fail++;
      $display("FAIL midrst_latency: got %0d expected 75", lat); end
    n_tests++; if (class_a !== 8'd6 || count_a !== 8'd64) begin n_fail++;
      $display("FAIL midrst_result: got %0d/%0d expected 6/64", class_a, count_a); end
  endtask

  task automatic test_saturation;
    do_window(1'b1, 10'b1000000000, 10'b1000000000, 1'b0);
    n_tests++; if (class_b !== 8'd9) begin n_fail++;
      $display("FAIL sat_class: got %0d expected 9", class_b); end
    n_tests++; if (count_b !== 4'd15) begin n_fail++;
      $display("FAIL sat_count: got %0d expected 15", count_b); end
    n_tests++; if (tie_b !== 1'b0) begin n_fail++;
      $display("FAIL sat_tie: got %b expected 0", tie_b); end
    do_window(1'b1, 10'b0000000001, 10'b0000000001, 1'b0);
    n_tests++; if (class_b !== 8'd0) begin n_fail++;
      $display("FAIL sat_clear_class: got %0d expected 0", class_b); end
    n_tests++; if (count_b !== 4'd15) begin n_fail++;
      $display("FAIL sat_clear_count: got %0d expected 15", count_b); end
    n_tests++; if (tie_b !== 1'b0) begin n_fail++;
      $display("FAIL sat_clear_tie: got %b expected 0", tie_b); end
  endtask

  task automatic test_empty_restart;
    do_window(1'b0, 10'b0, 10'b0, 1'b1);
    n_tests++; if (class_a !== 8'hFF) begin n_fail++;
      $display("FAIL empty_class: got %h expected ff", class_a); end
    n_tests++; if (count_a !== 8'd0) begin n_fail++;
      $display("FAIL empty_count: got %0d expected 0", count_a); end
    n_tests++; if (tie_a !== 1'b0) begin n_fail++;
      $display("FAIL empty_tie: got %b expected 0", tie_a); end
    n_tests++; if (pulses != 1 || lat != 75) begin n_fail++;
      $display("FAIL empty_pulses: got %0d at %0d expected 1 at 75", pulses, lat); end
    n_tests++; if (busy_end !== 1'b0) begin n_fail++;
      $display("FAIL empty_no_requeue: got busy %b expected 0", busy_end); end
  endtask

  initial begin
    test_reset();
    test_held();
    test_tie();
    test_mixed();
    test_reset_mid_window();
    test_saturation();
    test_empty_restart();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
